// File: rtl/conv_scheduler.sv
// Sequences a convolution unit over every output window of an H x W map in raster order,
// capturing each accumulated result and handing it downstream through a valid/ready port.
module conv_scheduler #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned D          = 1,
    parameter int unsigned F          = 5,
    parameter int unsigned H          = 32,
    parameter int unsigned W          = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            win_row,
    output logic [7:0]            win_col,
    output logic                  conv_reset,
    input  logic [DATA_WIDTH-1:0] conv_result,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned LAT      = D * F * F + 2;
    localparam int unsigned CNT_W    = $clog2(LAT);
    localparam int unsigned LAST_ROW = H - F;
    localparam int unsigned LAST_COL = W - F;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMPUTE,
        OUTPUT
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic [7:0]              row_next;
    logic [7:0]              col_next;
    logic [DATA_WIDTH-1:0]   data_next;
    logic                    valid_next;
    logic                    done_next;
    logic                    busy_next;
    logic                    conv_reset_next;
    logic                    last_win;
    logic                    handshake;

    assign last_win  = (win_row == 8'(LAST_ROW)) && (win_col == 8'(LAST_COL));
    assign handshake = out_valid && out_ready;

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            win_row    <= '0;
            win_col    <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            conv_reset <= 1'b1;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            win_row    <= row_next;
            win_col    <= col_next;
            out_data   <= data_next;
            out_valid  <= valid_next;
            done       <= done_next;
            busy       <= busy_next;
            conv_reset <= conv_reset_next;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        row_next   = win_row;
        col_next   = win_col;
        data_next  = out_data;
        valid_next = out_valid;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    row_next   = '0;
                    col_next   = '0;
                end
            end
            LOAD: begin
                state_next = COMPUTE;
                cnt_next   = '0;
            end
            COMPUTE: begin
                if (cnt == CNT_W'(LAT - 1)) begin
                    data_next  = conv_result;
                    valid_next = 1'b1;
                    state_next = OUTPUT;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            OUTPUT: begin
                if (handshake) begin
                    valid_next = 1'b0;
                    if (last_win) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = LOAD;
                        if (win_col == 8'(LAST_COL)) begin
                            col_next = '0;
                            row_next = win_row + 8'(1);
                        end else begin
                            col_next = win_col + 8'(1);
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Registered from the next state so they line up with the state register
        busy_next       = (state_next != IDLE);
        conv_reset_next = (state_next == IDLE) || (state_next == LOAD);
    end

endmodule

// File: tb/tb_conv_scheduler.sv
// Scoreboard bench for conv_scheduler: a 5x5 map with a 3x3 filter (nine windows)
// plus a 5x5 filter on a 5x5 map (single window).
module tb_conv_scheduler;

    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic [7:0]    win_row;
    logic [7:0]    win_col;
    logic          conv_reset;
    logic [DW-1:0] conv_result;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    logic          start1;
    logic          busy1;
    logic          done1;
    logic [7:0]    win_row1;
    logic [7:0]    win_col1;
    logic          conv_reset1;
    logic [DW-1:0] conv_result1;
    logic [DW-1:0] out_data1;
    logic          out_valid1;
    logic          out_ready1;

    always #5 clk = ~clk;

    conv_scheduler #(.DATA_WIDTH(DW), .D(1), .F(3), .H(5), .W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .win_row(win_row), .win_col(win_col), .conv_reset(conv_reset),
        .conv_result(conv_result), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    conv_scheduler #(.DATA_WIDTH(DW), .D(1), .F(5), .H(5), .W(5)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .win_row(win_row1), .win_col(win_col1), .conv_reset(conv_reset1),
        .conv_result(conv_result1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready1)
    );

    // Conv unit model: result tags the window it was computed for
    assign conv_result  = 16'h3C00 | (16'(win_row) << 4) | 16'(win_col);
    assign conv_result1 = 16'hA5A5;

    typedef struct {
        logic [7:0]    r;
        logic [7:0]    c;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            start_cyc = 0;
    int            last_rise = 0;
    int            done_cnt = 0;
    int            cr_len = 0;
    logic          prev_valid = 1'b0;
    logic          first_of_run = 1'b0;
    logic          chk_period = 1'b1;
    logic [DW-1:0] held_d;
    logic [7:0]    held_r;
    logic [7:0]    held_c;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on each new output and checks timing and stability
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            cr_len     = 0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(e.d));
                    check("win_row", 32'(win_row), 32'(e.r));
                    check("win_col", 32'(win_col), 32'(e.c));
                end
                if (first_of_run)
                    check("first_latency", 32'(cyc - start_cyc), 32'd12);
                else if (chk_period)
                    check("period", 32'(cyc - last_rise), 32'd13);
                first_of_run = 1'b0;
                last_rise    = cyc;
                held_d       = out_data;
                held_r       = win_row;
                held_c       = win_col;
            end else if (out_valid) begin
                check("hold_data", 32'(out_data), 32'(held_d));
                check("hold_row", 32'(win_row), 32'(held_r));
                check("hold_col", 32'(win_col), 32'(held_c));
                check("hold_no_load", 32'(conv_reset), 32'd0);
            end
            prev_valid = out_valid;
            if (done) begin
                done_cnt++;
                if (chk_period)
                    check("done_time", 32'(cyc - start_cyc), 32'd117);
                check("sb_empty_at_done", 32'(sb.size()), 32'd0);
            end
            if (busy && conv_reset) begin
                cr_len++;
            end else if (cr_len != 0) begin
                check("conv_reset_len", 32'(cr_len), 32'd1);
                cr_len = 0;
            end
        end
    end

    task automatic push_map();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                sb.push_back('{8'(r), 8'(c), 16'h3C00 | 16'(r << 4) | 16'(c)});
    endtask

    task automatic start_pulse();
        @(posedge clk); #1;
        start        = 1'b1;
        first_of_run = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) @(posedge clk);
        if (done_cnt < target) check("done_timeout", 32'(done_cnt), 32'(target));
        repeat (3) @(posedge clk);
        #1;
        check("done_count", 32'(done_cnt), 32'(target));
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_conv_reset", 32'(conv_reset), 32'd1);
    endtask

    task automatic check_reset_vals();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_row", 32'(win_row), 32'd0);
        check("rst_col", 32'(win_col), 32'd0);
        check("rst_conv_reset", 32'(conv_reset), 32'd1);
    endtask

    initial begin
        bit found;
        reset      = 1'b1;
        start      = 1'b0;
        out_ready  = 1'b1;
        start1     = 1'b0;
        out_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        reset = 1'b0;

        // Free-running map
        push_map();
        start_pulse();
        wait_done(1, 300);
        check("last_row_held", 32'(win_row), 32'd2);
        check("last_col_held", 32'(win_col), 32'd2);

        // start pulsed during COMPUTE is ignored
        push_map();
        start_pulse();
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(2, 300);

        // Back-pressure on window (1,1)
        push_map();
        chk_period = 1'b0;
        start_pulse();
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk); #1;
            if (out_valid && win_row == 8'd1 && win_col == 8'd1) begin
                out_ready = 1'b0;
                found     = 1'b1;
            end
        end
        check("stall_window_seen", 32'(found), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_row", 32'(win_row), 32'd1);
        check("stall_col", 32'(win_col), 32'd1);
        out_ready = 1'b1;
        wait_done(3, 400);
        chk_period = 1'b1;

        // Reset during COMPUTE of window (0,2)
        push_map();
        start_pulse();
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk); #1;
            if (busy && !out_valid && !conv_reset && win_row == 8'd0 && win_col == 8'd2)
                found = 1'b1;
        end
        check("compute_02_seen", 32'(found), 32'd1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check_reset_vals();
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("no_done_after_reset", 32'(done_cnt), 32'd3);
        check("idle_after_reset", 32'(busy), 32'd0);

        // Fresh start restarts at (0,0)
        push_map();
        start_pulse();
        wait_done(4, 300);

        // Single-window configuration
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        start_cyc = cyc;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk); #1;
            if (out_valid1) found = 1'b1;
        end
        check("single_valid_seen", 32'(found), 32'd1);
        check("single_latency", 32'(cyc - start_cyc), 32'd28);
        check("single_data", 32'(out_data1), 32'hA5A5);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (done1) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("single_done_seen", 32'(found), 32'd1);
        check("single_done_time", 32'(cyc - start_cyc), 32'd29);
        @(posedge clk); #1;
        check("single_done_pulse", 32'(done1), 32'd0);
        check("single_idle", 32'(busy1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_scheduler.md
CONV_SCHEDULER -- requirements
Module: conv_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning width of one feature value and of the result.
REQ-002 SHALL have parameter D, default 1, meaning filter depth.
REQ-003 SHALL have parameter F, default 5, meaning filter side length.
REQ-004 SHALL have parameter H, default 32, meaning input map height; legal range F..255.
REQ-005 SHALL have parameter W, default 32, meaning input map width; legal range F..255.
REQ-006 SHALL have port clk, input, 1, the clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-008 SHALL have port start, input, 1, request to process one full output map.
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 SHALL have port done, output, 1, single-cycle pulse after the last output is accepted.
REQ-011 SHALL have port win_row, output, 8, top row of the current window, selecting the image slice fed to the conv unit.
REQ-012 SHALL have port win_col, output, 8, left column of the current window.
REQ-013 SHALL have port conv_reset, output, 1, reset to the attached convolution unit.
REQ-014 SHALL have port conv_result, input, DATA_WIDTH, accumulated result from the convolution unit.
REQ-015 SHALL have port out_data, output, DATA_WIDTH, captured window result.
REQ-016 SHALL have port out_valid, output, 1, out_data valid.
REQ-017 SHALL have port out_ready, input, 1, downstream accepts out_data.

Function
REQ-018 SHALL define LAT = D*F*F+2, OR = H-F+1, OC = W-F+1; output windows SHALL be issued in raster order, col fastest: (0,0),(0,1)..(0,OC-1),(1,0)..(OR-1,OC-1).
REQ-019 SHALL implement states IDLE, LOAD, COMPUTE, OUTPUT.
REQ-020 IDLE: start=1 at an edge -> LOAD, win_row=win_col=0; start=0 -> stay.
REQ-021 LOAD (exactly 1 cycle): conv_reset=1, then -> COMPUTE with cycle counter cleared to 0.
REQ-022 COMPUTE: counter increments each edge; at the edge where counter==LAT-1, out_data<=conv_result, out_valid<=1, -> OUTPUT; win_row/win_col SHALL remain stable throughout LOAD and COMPUTE.
REQ-023 OUTPUT: out_data and out_valid held stable until out_valid&out_ready at an edge (the handshake).
REQ-024 On handshake, if the window is not last: out_valid<=0, advance win_col (wrap to 0 and increment win_row at OC-1), -> LOAD.
REQ-025 On handshake of the last window (OR-1,OC-1): out_valid<=0, done<=1 for one cycle, -> IDLE; win_row/win_col hold their last values.
REQ-026 start while busy SHALL be ignored; start held high in IDLE after done SHALL begin a new map on the next edge.
REQ-027 conv_reset SHALL be 1 in LOAD and IDLE and while reset is high, and 0 in COMPUTE and OUTPUT.
REQ-028 Per-window period with out_ready tied high SHALL be exactly LAT+2 cycles; full map SHALL take OR*OC*(LAT+2) cycles from the start edge to the done pulse.
REQ-029 Counter width SHALL hold LAT-1 without overflow; no arithmetic on conv_result (pass-through capture only).

Reset
REQ-030 reset high SHALL, asynchronously, force IDLE, busy=0, done=0, out_valid=0, out_data=0, win_row=0, win_col=0, counter=0, conv_reset=1.
REQ-031 reset asserted mid-operation (any state) SHALL abandon the map; no done pulse; operation resumes only on a fresh start after reset deassertion.

Verification
REQ-032 F=3,D=1,H=W=5, out_ready=1, start pulse -> 9 outputs, windows (0,0)..(2,2) in raster order, each out_valid exactly 13 cycles apart, done pulse 117 cycles after the start edge.
REQ-033 Same config, conv unit model returns 16'h3C00 -> first out_valid rises 12 edges after the start edge with out_data=16'h3C00, conv_reset high for exactly 1 cycle before each COMPUTE.
REQ-034 out_ready held low 20 cycles on window (1,1) -> out_valid and out_data stable for all 20 cycles, win_row=1, win_col=1 unchanged, no LOAD until ready.
REQ-035 Reset asserted during COMPUTE of window (0,2) -> outputs immediately at reset values, no done; a subsequent start restarts at (0,0).
REQ-036 start pulsed during COMPUTE -> ignored; exactly 9 outputs and one done pulse.
REQ-037 F=5,H=W=5 (single window) -> one output after LAT=27 compute cycles, done follows the only handshake.
